// File: rtl/fpga_hero_pkg.sv
// Shared definitions for the fpga_hero note-lane pipeline: default widths,
// the fetch scheduler state encoding and a small width helper.
package fpga_hero_pkg;

    localparam int NUM_SLOTS_DEF = 4;
    localparam int NOTE_W_DEF    = 4;
    localparam int ADDR_W_DEF    = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } sched_state_t;

    // Index width for n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/note_fetch_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first set request bit strictly after
// rr_ptr (wrapping) wins.
module rr_arbiter
    import fpga_hero_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int IDX_W = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] pending,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [WIDTH-1:0] winner,
    output logic [IDX_W-1:0] winner_idx
);

    logic             found_s;
    logic [IDX_W-1:0] cand_s;

    // Scan rr_ptr+1 .. rr_ptr+WIDTH modulo WIDTH; the last step revisits rr_ptr itself.
    always_comb begin
        winner     = {WIDTH{1'b0}};
        winner_idx = {IDX_W{1'b0}};
        found_s    = 1'b0;
        cand_s     = {IDX_W{1'b0}};
        for (int i = 1; i <= WIDTH; i++) begin
            cand_s = IDX_W'((int'(rr_ptr) + i) % WIDTH);
            if (!found_s && pending[cand_s]) begin
                found_s        = 1'b1;
                winner[cand_s] = 1'b1;
                winner_idx     = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/note_fetch_scheduler.sv
// Serializes notes-ROM reads for the beat slots: requests are latched once per
// frame, granted round-robin, and each grant consumes exactly one ROM line.
module note_fetch_scheduler
    import fpga_hero_pkg::*;
#(
    parameter int NUM_SLOTS   = NUM_SLOTS_DEF,
    parameter int NOTE_W      = NOTE_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int SONG_LEN    = 256,
    parameter int ROM_LATENCY = 2
) (
    input  logic                 vgaclk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 frame_tick,
    input  logic [NUM_SLOTS-1:0] req,
    input  logic [NOTE_W-1:0]    rom_q,
    output logic [ADDR_W-1:0]    rom_addr,
    output logic [NUM_SLOTS-1:0] grant,
    output logic [NOTE_W-1:0]    note_out,
    output logic                 busy,
    output logic                 song_wrap,
    output logic                 overrun
);

    localparam int IDX_W = idx_width(NUM_SLOTS);
    localparam int CNT_W = $clog2(ROM_LATENCY + 1);

    localparam logic [CNT_W-1:0]     LAT_LOAD   = CNT_W'(ROM_LATENCY);
    localparam logic [CNT_W-1:0]     CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]     CNT_ZERO   = CNT_W'(0);
    localparam logic [ADDR_W-1:0]    LAST_ADDR  = ADDR_W'(SONG_LEN - 1);
    localparam logic [ADDR_W-1:0]    ADDR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0]    ADDR_ZERO  = ADDR_W'(0);
    localparam logic [IDX_W-1:0]     PTR_RESET  = IDX_W'(NUM_SLOTS - 1);
    localparam logic [IDX_W-1:0]     IDX_ZERO   = IDX_W'(0);
    localparam logic [NUM_SLOTS-1:0] SLOTS_ZERO = NUM_SLOTS'(0);
    localparam logic [NOTE_W-1:0]    NOTE_ZERO  = NOTE_W'(0);

    sched_state_t         state_r;
    sched_state_t         state_s;
    logic [NUM_SLOTS-1:0] pending_r;
    logic [NUM_SLOTS-1:0] pending_s;
    logic [IDX_W-1:0]     rr_ptr_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [CNT_W-1:0]     cnt_s;
    logic [NUM_SLOTS-1:0] win_onehot_r;
    logic [IDX_W-1:0]     win_idx_r;
    logic [NUM_SLOTS-1:0] arb_onehot_s;
    logic [IDX_W-1:0]     arb_idx_s;

    logic [ADDR_W-1:0]    rom_addr_r;
    logic [NUM_SLOTS-1:0] grant_r;
    logic [NOTE_W-1:0]    note_out_r;
    logic                 busy_r;
    logic                 song_wrap_r;
    logic                 overrun_r;

    logic tick_s;
    logic deliver_s;
    logic launch_s;

    assign tick_s    = frame_tick & run;
    assign deliver_s = (state_r == DELIVER);
    // Outputs are registered, so the strobe is loaded on the edge that enters DELIVER.
    assign launch_s  = (state_r == WAIT) && (cnt_r == CNT_ONE);

    rr_arbiter #(
        .WIDTH      (NUM_SLOTS)
    ) u_arb (
        .pending    (pending_r),
        .rr_ptr     (rr_ptr_r),
        .winner     (arb_onehot_s),
        .winner_idx (arb_idx_s)
    );

    // Next-state and wait-counter logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (pending_r != SLOTS_ZERO) begin
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                state_s = WAIT;
                cnt_s   = LAT_LOAD;
            end
            WAIT: begin
                cnt_s = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    state_s = DELIVER;
                end else begin
                    state_s = WAIT;
                end
            end
            DELIVER: begin
                if ((pending_r & ~win_onehot_r) != SLOTS_ZERO) begin
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Pending set/clear; a frame's new requests take priority over the clear.
    always_comb begin
        pending_s = pending_r;
        if (tick_s && deliver_s) begin
            pending_s = (pending_r & ~win_onehot_r) | req;
        end else if (tick_s) begin
            pending_s = pending_r | req;
        end else if (deliver_s) begin
            pending_s = pending_r & ~win_onehot_r;
        end else begin
            pending_s = pending_r;
        end
    end

    // Control state registers.
    always_ff @(posedge vgaclk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            pending_r    <= SLOTS_ZERO;
            rr_ptr_r     <= PTR_RESET;
            cnt_r        <= CNT_ZERO;
            win_onehot_r <= SLOTS_ZERO;
            win_idx_r    <= IDX_ZERO;
        end else begin
            state_r   <= state_s;
            pending_r <= pending_s;
            cnt_r     <= cnt_s;
            if (state_r == ISSUE) begin
                win_onehot_r <= arb_onehot_s;
                win_idx_r    <= arb_idx_s;
            end
            if (deliver_s) begin
                rr_ptr_r <= win_idx_r;
            end
        end
    end

    // Registered outputs; rom_addr moves only at the end of DELIVER.
    always_ff @(posedge vgaclk or posedge rst) begin
        if (rst) begin
            rom_addr_r  <= ADDR_ZERO;
            grant_r     <= SLOTS_ZERO;
            note_out_r  <= NOTE_ZERO;
            busy_r      <= 1'b0;
            song_wrap_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            grant_r     <= launch_s ? win_onehot_r : SLOTS_ZERO;
            song_wrap_r <= launch_s && (rom_addr_r == LAST_ADDR);
            busy_r      <= (state_s != IDLE);
            if (launch_s) begin
                note_out_r <= rom_q;
            end
            if (deliver_s) begin
                rom_addr_r <= (rom_addr_r == LAST_ADDR) ? ADDR_ZERO : rom_addr_r + ADDR_ONE;
            end
            if (tick_s && (state_r != IDLE)) begin
                overrun_r <= 1'b1;
            end
        end
    end

    assign rom_addr  = rom_addr_r;
    assign grant     = grant_r;
    assign note_out  = note_out_r;
    assign busy      = busy_r;
    assign song_wrap = song_wrap_r;
    assign overrun   = overrun_r;

endmodule
